// File: rtl/key_meter.sv
// key_meter: per-key attack/sustain/release envelope tracker feeding the bar renderer.
// Optional macro FRAME_LATCH_EN: outputs come from shadow registers loaded at frame start.
module key_meter #(
  parameter int N_KEYS   = 8,
  parameter int LVL_W    = 3,
  parameter int TICK_DIV = 1_562_500
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_KEYS-1:0]         play_i,
  input  logic [LVL_W-1:0]          gain_i,
  input  logic [LVL_W-1:0]          octave_i,
  input  logic                      frame_start_i,
  output logic [N_KEYS-1:0]         play_o,
  output logic [N_KEYS*LVL_W-1:0]   vol_o,
  output logic [N_KEYS*LVL_W-1:0]   freq_o,
  output logic                      active_o
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [LVL_W-1:0] ONE = LVL_W'(1);

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} key_state_t;

  logic [CNT_W-1:0]          tick_cnt;
  logic                      tick;
  logic [N_KEYS-1:0]         play_int;
  logic [N_KEYS*LVL_W-1:0]   vol_int;
  logic [N_KEYS*LVL_W-1:0]   freq_int;

  // Shared envelope prescaler; tick is the single terminal-count cycle.
  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + CNT_W'(1);
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_state_t       state;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] octave;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state  <= IDLE;
        level  <= '0;
        octave <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (play_i[k]) begin
              state  <= ATTACK;
              octave <= octave_i;
            end
          end
          ATTACK: begin
            // Key release wins over a coincident tick and freezes the level.
            if (!play_i[k]) begin
              state <= RELEASE;
            end else if (tick) begin
              if (level < gain_i) begin
                level <= level + ONE;
                if (level + ONE == gain_i)
                  state <= SUSTAIN;
              end else begin
                level <= gain_i;
                state <= SUSTAIN;
              end
            end
          end
          SUSTAIN: begin
            level <= gain_i;
            if (!play_i[k])
              state <= RELEASE;
          end
          RELEASE: begin
            if (play_i[k]) begin
              state  <= ATTACK;
              octave <= octave_i;
            end else if (level == '0) begin
              state <= IDLE;
            end else if (tick) begin
              level <= level - ONE;
              if (level == ONE)
                state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign play_int[k]                   = (state != IDLE);
    assign vol_int[LVL_W*k +: LVL_W]     = level;
    assign freq_int[LVL_W*k +: LVL_W]    = (state != IDLE) ? octave : '0;
  end

`ifdef FRAME_LATCH_EN
  // Shadows only move at frame boundaries so the renderer never sees a torn frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      play_o   <= '0;
      vol_o    <= '0;
      freq_o   <= '0;
      active_o <= 1'b0;
    end else if (frame_start_i) begin
      play_o   <= play_int;
      vol_o    <= vol_int;
      freq_o   <= freq_int;
      active_o <= |play_int;
    end
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start_i;

  assign play_o   = play_int;
  assign vol_o    = vol_int;
  assign freq_o   = freq_int;
  assign active_o = |play_int;
`endif

endmodule

// File: tb/tb_key_meter.sv
// Self-checking bench for key_meter (TICK_DIV=4) against a behavioural envelope model.
// Also covers the FRAME_LATCH_EN build when that macro is defined.
module tb_key_meter;
  localparam int N   = 8;
  localparam int W   = 3;
  localparam int DIV = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    play_i;
  logic [W-1:0]    gain_i;
  logic [W-1:0]    octave_i;
  logic            frame_start_i;
  logic [N-1:0]    play_o;
  logic [N*W-1:0]  vol_o;
  logic [N*W-1:0]  freq_o;
  logic            active_o;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 rising, 2 holding at gain, 3 falling.
  int m_phase [N];
  int m_lvl   [N];
  int m_oct   [N];
  int m_cnt;
  logic [N-1:0]   sh_play;
  logic [N*W-1:0] sh_vol;
  logic [N*W-1:0] sh_freq;

  key_meter #(.N_KEYS(N), .LVL_W(W), .TICK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .play_i(play_i), .gain_i(gain_i),
    .octave_i(octave_i), .frame_start_i(frame_start_i),
    .play_o(play_o), .vol_o(vol_o), .freq_o(freq_o), .active_o(active_o)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    for (int k = 0; k < N; k++) begin
      m_phase[k] = 0; m_lvl[k] = 0; m_oct[k] = 0;
    end
    m_cnt = 0; sh_play = '0; sh_vol = '0; sh_freq = '0;
  endfunction

  function automatic void modelVectors(output logic [N-1:0] p, output logic [N*W-1:0] v,
                                       output logic [N*W-1:0] f);
    p = '0; v = '0; f = '0;
    for (int k = 0; k < N; k++) begin
      p[k] = (m_phase[k] != 0);
      v[W*k +: W] = 3'(m_lvl[k]);
      f[W*k +: W] = p[k] ? 3'(m_oct[k]) : 3'd0;
    end
  endfunction

  // Advance the model by one clock edge using the inputs present before the edge.
  function automatic void modelEdge();
    logic [N-1:0] pp; logic [N*W-1:0] vv, ff;
    bit tick;
    int g;
    modelVectors(pp, vv, ff);
    if (frame_start_i) begin sh_play = pp; sh_vol = vv; sh_freq = ff; end
    tick = (m_cnt == DIV - 1);
    m_cnt = (m_cnt + 1) % DIV;
    g = int'(gain_i);
    for (int k = 0; k < N; k++) begin
      case (m_phase[k])
        0: if (play_i[k]) begin m_phase[k] = 1; m_oct[k] = int'(octave_i); end
        1: if (!play_i[k]) m_phase[k] = 3;
           else if (tick) begin
             m_lvl[k] = (m_lvl[k] + 1 < g) ? m_lvl[k] + 1 : g;
             if (m_lvl[k] >= g) m_phase[k] = 2;
           end
        2: begin m_lvl[k] = g; if (!play_i[k]) m_phase[k] = 3; end
        default: if (play_i[k]) begin m_phase[k] = 1; m_oct[k] = int'(octave_i); end
                 else if (m_lvl[k] == 0) m_phase[k] = 0;
                 else if (tick) begin
                   m_lvl[k] = m_lvl[k] - 1;
                   if (m_lvl[k] == 0) m_phase[k] = 0;
                 end
      endcase
    end
  endfunction

  task automatic checkOutput(input string tag);
    logic [N-1:0] ep; logic [N*W-1:0] ev, ef; logic ea;
`ifdef FRAME_LATCH_EN
    ep = sh_play; ev = sh_vol; ef = sh_freq;
`else
    modelVectors(ep, ev, ef);
`endif
    ea = |ep;
    checks++;
    assert (play_o === ep) else begin errors++; $error("FAIL %s play_o got %h want %h", tag, play_o, ep); end
    checks++;
    assert (vol_o === ev) else begin errors++; $error("FAIL %s vol_o got %o want %o", tag, vol_o, ev); end
    checks++;
    assert (freq_o === ef) else begin errors++; $error("FAIL %s freq_o got %o want %o", tag, freq_o, ef); end
    checks++;
    assert (active_o === ea) else begin errors++; $error("FAIL %s active_o got %b want %b", tag, active_o, ea); end
  endtask

  task automatic applyStimulus(input logic [N-1:0] p, input logic [W-1:0] g, input logic [W-1:0] o,
                               input logic fs, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      play_i = p; gain_i = g; octave_i = o; frame_start_i = fs;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput(tag);
    end
    frame_start_i = 1'b0;
  endtask

  task automatic checkZero(input string tag);
    checks++;
    assert (play_o === '0 && vol_o === '0 && freq_o === '0 && active_o === 1'b0)
      else begin errors++; $error("FAIL %s outputs got %h/%o/%o/%b want all 0", tag, play_o, vol_o, freq_o, active_o); end
  endtask

  initial begin
    logic [N-1:0] rp;
    reset = 1'b0; play_i = '0; gain_i = '0; octave_i = '0; frame_start_i = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 checkZero("reset");
    #2 reset = 1'b1;

    applyStimulus(8'h04, 3'd5, 3'd3, 1'b0, 24, "attack");
    applyStimulus(8'h04, 3'd5, 3'd3, 1'b1, 1, "frame1");
    applyStimulus(8'h04, 3'd2, 3'd3, 1'b0, 2, "gain_drop");
    applyStimulus(8'h04, 3'd5, 3'd3, 1'b0, 2, "gain_up");

    for (int i = 0; i < 40 && m_lvl[2] != 3; i++)
      applyStimulus(8'h00, 3'd5, 3'd3, 1'b0, 1, "release");
    applyStimulus(8'h04, 3'd5, 3'd6, 1'b0, 12, "repress");
    applyStimulus(8'h04, 3'd5, 3'd6, 1'b1, 1, "frame2");
    applyStimulus(8'h00, 3'd5, 3'd6, 1'b0, 24, "release_all");
    applyStimulus(8'h00, 3'd5, 3'd6, 1'b1, 1, "frame3");

    applyStimulus(8'h01, 3'd0, 3'd2, 1'b0, 10, "gain0");
    applyStimulus(8'h00, 3'd0, 3'd2, 1'b0, 3, "gain0_rel");

    applyStimulus(8'h20, 3'd7, 3'd4, 1'b0, 6, "tick_rel_pre");
    for (int i = 0; i < DIV && m_cnt != DIV - 1; i++)
      applyStimulus(8'h20, 3'd7, 3'd4, 1'b0, 1, "tick_align");
    applyStimulus(8'h00, 3'd7, 3'd4, 1'b0, 1, "tick_rel");
    applyStimulus(8'h00, 3'd7, 3'd4, 1'b0, 40, "tick_rel_post");

    applyStimulus(8'hFF, 3'd7, 3'd1, 1'b0, 30, "all_keys");
    applyStimulus(8'hFF, 3'd7, 3'd1, 1'b1, 1, "frame4");
    checks++;
    assert (vol_o === 24'o77777777)
      else begin errors++; $error("FAIL all_keys_full vol_o got %o want %o", vol_o, 24'o77777777); end
    applyStimulus(8'h00, 3'd7, 3'd1, 1'b0, 40, "all_rel");

    applyStimulus(8'h08, 3'd6, 3'd5, 1'b0, 6, "pre_async");
    #2 reset = 1'b0;
    #1 checkZero("async_reset");
    modelReset();
    play_i = '0;
    repeat (2) begin
      @(posedge clk);
      #1 checkOutput("in_reset");
    end
    #2 reset = 1'b1;
    applyStimulus(8'h00, 3'd6, 3'd5, 1'b1, 4, "post_reset");

    rp = '0;
    for (int i = 0; i < 300; i++) begin
      rp = rp ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      applyStimulus(rp, (i % 16 == 0) ? 3'($urandom_range(0, 7)) : gain_i, 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 5) == 0), 1, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
